// File: rtl/i2c_txn_sequencer_if.sv
// Signal bundle between the host logic, the transaction sequencer and the I2C master.
// The master modport is the sequencer's view; slave is the view of whatever surrounds it.
interface i2c_txn_sequencer_if;
  // Host request / response
  logic       req;
  logic       rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] rdata;
  // I2C master control
  logic [6:0] m_address;
  logic [7:0] m_register;
  logic       m_mode;
  logic       m_en;
  logic       m_start;
  logic       m_stop;
  logic       m_repeat_start;
  logic       m_rst_n;
  logic [7:0] m_out;
  logic       m_ack;

  modport master (
    input  req, rw, dev_addr, reg_addr, wdata, m_out, m_ack,
    output busy, done, err, rdata,
    output m_address, m_register, m_mode, m_en, m_start, m_stop, m_repeat_start, m_rst_n
  );

  modport slave (
    output req, rw, dev_addr, reg_addr, wdata, m_out, m_ack,
    input  busy, done, err, rdata,
    input  m_address, m_register, m_mode, m_en, m_start, m_stop, m_repeat_start, m_rst_n
  );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// Sequences single-byte I2C register reads/writes by counting master ack pulses, with a
// watchdog abort and a master reset pulse after every transaction.
module i2c_txn_sequencer #(
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned RST_CYCLES = 2
) (
  input logic                   clk_4x,
  input logic                   reset,
  i2c_txn_sequencer_if.master   bus
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam int unsigned RcW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCapture,
    StFinish,
    StRecover,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic           ack_q;
  logic           ack_edge;
  logic [2:0]     cnt_q, cnt_d, cnt_inc;
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           wdog_expired;
  logic [RcW-1:0] rst_cnt_q, rst_cnt_d;
  logic           rst_last;

  logic       rw_q, rw_d;
  logic [7:0] wdata_q, wdata_d;
  logic       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic [6:0] m_address_q, m_address_d;
  logic [7:0] m_register_q, m_register_d;
  logic       m_mode_q, m_mode_d;
  logic       m_en_q, m_en_d;
  logic       m_start_q, m_start_d;
  logic       m_stop_q, m_stop_d;
  logic       m_repeat_start_q, m_repeat_start_d;
  logic       m_rst_n_q, m_rst_n_d;
  logic       busy, done;

  assign ack_edge     = bus.m_ack & ~ack_q;
  assign cnt_inc      = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
  assign wdog_expired = (wdog_q == WdW'(TIMEOUT - 1));
  assign rst_last     = (rst_cnt_q == RcW'(RST_CYCLES - 1));

  // State register
  always_ff @(posedge clk_4x or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      ack_q            <= 1'b0;
      cnt_q            <= 3'd0;
      wdog_q           <= '0;
      rst_cnt_q        <= '0;
      rw_q             <= 1'b0;
      wdata_q          <= 8'h00;
      err_q            <= 1'b0;
      rdata_q          <= 8'h00;
      m_address_q      <= 7'h00;
      m_register_q     <= 8'h00;
      m_mode_q         <= 1'b0;
      m_en_q           <= 1'b0;
      m_start_q        <= 1'b0;
      m_stop_q         <= 1'b0;
      m_repeat_start_q <= 1'b0;
      m_rst_n_q        <= 1'b1;
    end else begin
      state_q          <= state_d;
      ack_q            <= bus.m_ack;
      cnt_q            <= cnt_d;
      wdog_q           <= wdog_d;
      rst_cnt_q        <= rst_cnt_d;
      rw_q             <= rw_d;
      wdata_q          <= wdata_d;
      err_q            <= err_d;
      rdata_q          <= rdata_d;
      m_address_q      <= m_address_d;
      m_register_q     <= m_register_d;
      m_mode_q         <= m_mode_d;
      m_en_q           <= m_en_d;
      m_start_q        <= m_start_d;
      m_stop_q         <= m_stop_d;
      m_repeat_start_q <= m_repeat_start_d;
      m_rst_n_q        <= m_rst_n_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req) state_d = StWait;
      end
      StWait: begin
        if (ack_edge) begin
          if (!rw_q && cnt_inc == 3'd3) begin
            state_d = StFinish;
          end else if (rw_q && cnt_inc == 3'd4) begin
            state_d = StCapture;
          end
        end else if (wdog_expired) begin
          state_d = StFinish;
        end
      end
      StCapture: state_d = StFinish;
      StFinish:  state_d = StRecover;
      StRecover: begin
        if (rst_last) state_d = StDone;
      end
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d            = cnt_q;
    wdog_d           = wdog_q;
    rst_cnt_d        = rst_cnt_q;
    rw_d             = rw_q;
    wdata_d          = wdata_q;
    err_d            = err_q;
    rdata_d          = rdata_q;
    m_address_d      = m_address_q;
    m_register_d     = m_register_q;
    m_mode_d         = m_mode_q;
    m_en_d           = m_en_q;
    m_start_d        = m_start_q;
    m_stop_d         = m_stop_q;
    m_repeat_start_d = m_repeat_start_q;
    m_rst_n_d        = m_rst_n_q;
    busy             = (state_q != StIdle) && (state_q != StDone);
    done             = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          rw_d             = bus.rw;
          wdata_d          = bus.wdata;
          m_address_d      = bus.dev_addr;
          m_register_d     = bus.reg_addr;
          m_mode_d         = 1'b0;
          m_en_d           = 1'b1;
          m_start_d        = 1'b1;
          m_stop_d         = 1'b0;
          m_repeat_start_d = 1'b0;
          err_d            = 1'b0;
          cnt_d            = 3'd0;
          wdog_d           = '0;
        end
      end
      StWait: begin
        if (ack_edge) begin
          cnt_d  = cnt_inc;
          wdog_d = '0;
          case (cnt_inc)
            3'd1: m_start_d = 1'b0;
            3'd2: begin
              if (rw_q) begin
                m_repeat_start_d = 1'b1;
                m_mode_d         = 1'b1;
              end else begin
                m_register_d = wdata_q;
              end
            end
            3'd3: begin
              m_repeat_start_d = 1'b0;
              m_stop_d         = 1'b1;
            end
            default: ;
          endcase
        end else if (wdog_expired) begin
          // Master has parked (typically after a NACK); abort.
          err_d  = 1'b1;
          wdog_d = '0;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end
      StCapture: rdata_d = bus.m_out;
      StFinish: begin
        m_en_d           = 1'b0;
        m_stop_d         = 1'b0;
        m_start_d        = 1'b0;
        m_repeat_start_d = 1'b0;
        m_rst_n_d        = 1'b0;
        rst_cnt_d        = '0;
      end
      StRecover: begin
        if (rst_last) begin
          m_rst_n_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RcW'(1);
        end
      end
      StDone: ;
      default: ;
    endcase
  end

  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.err            = err_q;
  assign bus.rdata          = rdata_q;
  assign bus.m_address      = m_address_q;
  assign bus.m_register     = m_register_q;
  assign bus.m_mode         = m_mode_q;
  assign bus.m_en           = m_en_q;
  assign bus.m_start        = m_start_q;
  assign bus.m_stop         = m_stop_q;
  assign bus.m_repeat_start = m_repeat_start_q;
  assign bus.m_rst_n        = m_rst_n_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer: the bench plays the I2C master; a monitor checks each
// done pulse against a scoreboard of expected completions.
module tb_i2c_txn_sequencer;

  logic clk_4x;
  logic reset;

  i2c_txn_sequencer_if bus ();

  i2c_txn_sequencer #(
    .TIMEOUT   (64),
    .RST_CYCLES(2)
  ) dut (
    .clk_4x(clk_4x),
    .reset (reset),
    .bus   (bus)
  );

  initial clk_4x = 1'b0;
  always #5 clk_4x = ~clk_4x;

  typedef struct packed {
    logic       err;
    logic       chk_rd;
    logic [7:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected completion
  always @(negedge clk_4x) begin
    if (reset && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no completion");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_err", {31'd0, bus.err}, {31'd0, e.err});
        if (e.chk_rd) chk("done_rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
      end
    end
  end

  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                       input logic [7:0] wd);
    @(negedge clk_4x);
    bus.req      = 1'b1;
    bus.rw       = rw;
    bus.dev_addr = dev;
    bus.reg_addr = ra;
    bus.wdata    = wd;
    @(negedge clk_4x);
    bus.req = 1'b0;
  endtask

  // Ack pulse held for len cycles, then a short gap; returns with reactions visible
  task automatic ack_pulse(input int len);
    bus.m_ack = 1'b1;
    repeat (len) @(negedge clk_4x);
    bus.m_ack = 1'b0;
    repeat (2) @(negedge clk_4x);
  endtask

  task automatic wait_done(input int bound, output int rst_low);
    bit seen;
    seen    = 1'b0;
    rst_low = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk_4x);
      if (bus.m_rst_n === 1'b0) rst_low++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", bound);
    end else begin
      @(negedge clk_4x);
      chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
      chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    chk({tag, "_rdata"}, {24'd0, bus.rdata}, 32'd0);
    chk({tag, "_addr"}, {25'd0, bus.m_address}, 32'd0);
    chk({tag, "_reg"}, {24'd0, bus.m_register}, 32'd0);
    chk({tag, "_ctl"}, {27'd0, bus.m_mode, bus.m_en, bus.m_start, bus.m_stop,
                        bus.m_repeat_start}, 32'd0);
    chk({tag, "_mrstn"}, {31'd0, bus.m_rst_n}, 32'd1);
  endtask

  int rst_low;

  initial begin
    reset          = 1'b0;
    bus.req        = 1'b0;
    bus.rw         = 1'b0;
    bus.dev_addr   = 7'h00;
    bus.reg_addr   = 8'h00;
    bus.wdata      = 8'h00;
    bus.m_out      = 8'h00;
    bus.m_ack      = 1'b0;
    repeat (3) @(negedge clk_4x);
    check_reset_values("rst");
    reset = 1'b1;

    // Write 0xA5 to dev 0x50 reg 0x12
    exp_q.push_back('{err: 1'b0, chk_rd: 1'b0, rdata: 8'h00});
    issue(1'b0, 7'h50, 8'h12, 8'hA5);
    chk("wr_addr", {25'd0, bus.m_address}, 32'h50);
    chk("wr_reg0", {24'd0, bus.m_register}, 32'h12);
    chk("wr_start", {31'd0, bus.m_start}, 32'd1);
    chk("wr_en", {31'd0, bus.m_en}, 32'd1);
    chk("wr_busy", {31'd0, bus.busy}, 32'd1);
    ack_pulse(1);
    chk("wr_ack1_start", {31'd0, bus.m_start}, 32'd0);
    chk("wr_ack1_reg", {24'd0, bus.m_register}, 32'h12);
    ack_pulse(1);
    chk("wr_ack2_reg", {24'd0, bus.m_register}, 32'hA5);
    chk("wr_ack2_stop", {31'd0, bus.m_stop}, 32'd0);
    bus.m_ack = 1'b1;
    @(negedge clk_4x);
    bus.m_ack = 1'b0;
    chk("wr_ack3_stop", {31'd0, bus.m_stop}, 32'd1);
    wait_done(40, rst_low);
    chk("wr_rst_low", rst_low, 32'd2);
    chk("wr_en_off", {31'd0, bus.m_en}, 32'd0);

    // Read dev 0x48 reg 0x03, ack 2 held three cycles
    exp_q.push_back('{err: 1'b0, chk_rd: 1'b1, rdata: 8'h3C});
    issue(1'b1, 7'h48, 8'h03, 8'h00);
    chk("rd_mode0", {31'd0, bus.m_mode}, 32'd0);
    ack_pulse(1);
    bus.m_ack = 1'b1;
    @(negedge clk_4x);
    chk("rd_ack2_rs", {31'd0, bus.m_repeat_start}, 32'd1);
    chk("rd_ack2_mode", {31'd0, bus.m_mode}, 32'd1);
    repeat (2) @(negedge clk_4x);
    bus.m_ack = 1'b0;
    repeat (2) @(negedge clk_4x);
    chk("rd_held_noskip", {31'd0, bus.m_stop}, 32'd0);
    chk("rd_held_rs", {31'd0, bus.m_repeat_start}, 32'd1);
    ack_pulse(1);
    chk("rd_ack3_rs", {31'd0, bus.m_repeat_start}, 32'd0);
    chk("rd_ack3_stop", {31'd0, bus.m_stop}, 32'd1);
    bus.m_out = 8'h3C;
    bus.m_ack = 1'b1;
    @(negedge clk_4x);
    bus.m_ack = 1'b0;
    wait_done(40, rst_low);
    chk("rd_rst_low", rst_low, 32'd2);
    bus.m_out = 8'h00;

    // NACK: only the address ack arrives
    exp_q.push_back('{err: 1'b1, chk_rd: 1'b0, rdata: 8'h00});
    issue(1'b0, 7'h20, 8'h44, 8'h55);
    ack_pulse(1);
    repeat (58) @(negedge clk_4x);
    chk("nack_still_busy", {31'd0, bus.busy}, 32'd1);
    chk("nack_err_early", {31'd0, bus.err}, 32'd0);
    wait_done(40, rst_low);
    chk("nack_rst_low", rst_low, 32'd2);
    chk("nack_err_held", {31'd0, bus.err}, 32'd1);

    // req while busy is ignored; err cleared by the new accept
    exp_q.push_back('{err: 1'b0, chk_rd: 1'b0, rdata: 8'h00});
    issue(1'b0, 7'h11, 8'h22, 8'h33);
    chk("busy_err_clr", {31'd0, bus.err}, 32'd0);
    bus.req      = 1'b1;
    bus.dev_addr = 7'h7F;
    repeat (3) @(negedge clk_4x);
    bus.req = 1'b0;
    chk("busy_addr_kept", {25'd0, bus.m_address}, 32'h11);
    ack_pulse(1);
    chk("busy_addr_kept2", {25'd0, bus.m_address}, 32'h11);
    ack_pulse(1);
    chk("busy_reg_wdata", {24'd0, bus.m_register}, 32'h33);
    bus.m_ack = 1'b1;
    @(negedge clk_4x);
    bus.m_ack = 1'b0;
    wait_done(40, rst_low);
    repeat (4) @(negedge clk_4x);
    chk("busy_no_reaccept", {31'd0, bus.busy}, 32'd0);

    // Reset asserted at ack 2 of a read: no done pulse expected
    issue(1'b1, 7'h48, 8'h03, 8'h00);
    ack_pulse(1);
    bus.m_ack = 1'b1;
    @(negedge clk_4x);
    reset     = 1'b0;
    bus.m_ack = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk_4x);
    reset = 1'b1;
    repeat (2) @(negedge clk_4x);

    // Fresh write after the reset
    exp_q.push_back('{err: 1'b0, chk_rd: 1'b0, rdata: 8'h00});
    issue(1'b0, 7'h50, 8'h12, 8'h5A);
    chk("post_addr", {25'd0, bus.m_address}, 32'h50);
    ack_pulse(1);
    ack_pulse(1);
    chk("post_reg", {24'd0, bus.m_register}, 32'h5A);
    bus.m_ack = 1'b1;
    @(negedge clk_4x);
    bus.m_ack = 1'b0;
    wait_done(40, rst_low);
    chk("post_rst_low", rst_low, 32'd2);

    repeat (4) @(negedge clk_4x);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
Transaction sequencer directly upstream of the I2C master. Takes a single-byte register read or write request from the host logic and drives the master's address/register/mode/en/Start/Stop/repeat_start inputs. Advances by counting the master's ack pulses and captures read data from the master's out bus. Also owns the master's reset so the master can be returned to idle after it parks in its terminal state.

Parameters:
TIMEOUT, 64, max clk_4x cycles allowed between consecutive m_ack rising edges before the transaction is aborted.
RST_CYCLES, 2, number of clk_4x cycles m_rst_n is held low during recovery.

Ports:
clk_4x  in  1  clock; same source as the master's clk_4x_offset.
reset  in  1  asynchronous, active-low reset.
req  in  1  start a transaction; sampled only in IDLE.
rw  in  1  1 = read, 0 = write.
dev_addr  in  7  7-bit device address.
reg_addr  in  8  target register pointer.
wdata  in  8  write data byte.
busy  out  1  high from request accept until done.
done  out  1  one-cycle completion pulse.
err  out  1  timeout flag, valid with done; held until next accept.
rdata  out  8  read byte, valid with done when rw=1 and err=0.
m_address  out  7  to master address.
m_register  out  8  to master register.
m_mode  out  1  to master mode.
m_en  out  1  to master en.
m_start  out  1  to master Start.
m_stop  out  1  to master Stop.
m_repeat_start  out  1  to master repeat_start.
m_rst_n  out  1  to master reset, active-low.
m_out  in  8  from master out.
m_ack  in  1  from master ack.

Behaviour:
- Reset values:
  - all outputs 0, except m_rst_n = 1.
  - state IDLE, ack counter 0, watchdog 0.
  - asserting reset mid-transaction aborts immediately with no done pulse.
- Ack edge detection:
  - ack_q <= m_ack every cycle; ack_edge = m_ack & ~ack_q.
  - All reactions happen on the same clk_4x edge that sees ack_edge, so the master observes them on its next clk_4x_offset edge.
- Accept (IDLE & req):
  - latch rw, dev_addr, reg_addr, wdata.
  - m_address = dev_addr, m_register = reg_addr, m_mode = 0.
  - m_en = 1, m_start = 1, busy = 1, err = 0, ack count = 0.
  - req while busy is ignored.
- Ack #1 (address ack): m_start = 0.
- Write path (rw = 0, 3 acks expected):
  - ack #2 (pointer byte): m_register = wdata.
  - ack #3 (data byte): m_stop = 1 -> go to FINISH.
- Read path (rw = 1, 4 acks expected):
  - ack #2 (pointer byte): m_repeat_start = 1, m_mode = 1.
  - ack #3 (read-address ack): m_repeat_start = 0, m_stop = 1.
  - ack #4 (read byte): go to CAPTURE.
- CAPTURE: one cycle later, rdata <= m_out, then go to FINISH.
- FINISH:
  - m_en = 0, m_stop = 0, m_start = 0, m_repeat_start = 0.
  - then RECOVER.
- RECOVER:
  - m_rst_n = 0 for RST_CYCLES cycles, then 1.
  - then DONE.
- DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- Watchdog:
  - cleared on accept and on every ack_edge; increments while busy in the ack-waiting states.
  - on reaching TIMEOUT: err = 1, go to FINISH.
  - this covers a NACK, after which the master parks in its terminal state with no further acks.
- Unexpected ack_edge in FINISH/RECOVER/DONE/IDLE is ignored.
- Ack count is 3 bits and saturates at 4.

Test Plan:
- Write dev 0x50, reg 0x12, data 0xA5; bench emits 3 ack pulses -> m_register 0x12 then 0xA5; m_stop rises on ack 3; m_rst_n low 2 cycles; done=1, err=0.
- Read dev 0x48, reg 0x03; bench emits 4 acks with m_out=0x3C at ack 4 -> m_mode 0->1 and repeat_start pulse at ack 2; m_stop rises at ack 3; rdata=0x3C, err=0.
- NACK: only ack 1 delivered -> after 64 idle cycles err=1, master reset pulse, done pulse; next request accepted with err cleared.
- req asserted while busy with different dev_addr -> ignored; m_address stays at first value.
- Reset asserted at ack 2 of a read -> all outputs to reset values immediately; no done pulse; fresh request completes normally.
- m_ack held high for 3 cycles -> counted as one ack, ack count does not skip.
